mem_access_ctrl: RTL

Multi-cycle memory-stage controller for the ARM32 pipeline that replaces the single-cycle memory-stage decode for LDR/STR. It evaluates the condition code against NZCV and drives a req/ack data-memory handshake with arbitrary wait states. It stalls the upstream pipeline while an access is in flight and issues register-file writes for load data and base-register writeback. It is parametrised in data/address width and supports word and byte accesses.

---
 rtl/mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// LDR/STR memory-stage controller: condition check, req/ack data-memory handshake, register-file writeback.
// Optional access watchdog is built when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          cond,
    input  logic [31:0]         status_reg,
    input  logic                is_load,
    input  logic                is_store,
    input  logic                size_byte,
    input  logic                wb_base,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [ADDR_W-1:0]   base_new,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [3:0]          rd,
    input  logic [3:0]          rn,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                rf_w_en1,
    output logic [3:0]          rf_w_addr1,
    output logic [DATA_W-1:0]   rf_w_data1,
    output logic                rf_w_en2,
    output logic [3:0]          rf_w_addr2,
    output logic [ADDR_W-1:0]   rf_w_data2,
    output logic                fault
);
    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic                rf_w_en1_q, rf_w_en1_d;
    logic [3:0]          rf_w_addr1_q, rf_w_addr1_d;
    logic [DATA_W-1:0]   rf_w_data1_q, rf_w_data1_d;
    logic                rf_w_en2_q, rf_w_en2_d;
    logic [3:0]          rf_w_addr2_q, rf_w_addr2_d;
    logic [ADDR_W-1:0]   rf_w_data2_q, rf_w_data2_d;
    logic                load_q, load_d;
    logic                wb_q, wb_d;
    logic                byte_q, byte_d;
    logic [3:0]          rd_q, rd_d;
    logic [3:0]          rn_q, rn_d;
    logic [ADDR_W-1:0]   base_q, base_d;

    logic                exec;
    logic [LANE_W+2:0]   rshift;
    logic [7:0]          rbyte;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fault_q, fault_d;
`endif

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
        logic n, z, cf, v;
        {n, z, cf, v} = nzcv;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cf;
            4'b0011: cond_pass = ~cf;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cf & ~z;
            4'b1001: cond_pass = ~cf | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        rf_w_en1_d   = 1'b0;
        rf_w_addr1_d = rf_w_addr1_q;
        rf_w_data1_d = rf_w_data1_q;
        rf_w_en2_d   = 1'b0;
        rf_w_addr2_d = rf_w_addr2_q;
        rf_w_data2_d = rf_w_data2_q;
        load_d       = load_q;
        wb_d         = wb_q;
        byte_d       = byte_q;
        rd_d         = rd_q;
        rn_d         = rn_q;
        base_d       = base_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        fault_d      = 1'b0;
`endif

        exec   = in_valid && (state_q == IDLE) && cond_pass(cond, status_reg[31:28])
                 && (is_load || is_store);
        rshift = {mem_addr_q[LANE_W-1:0], 3'b000};
        rbyte  = mem_rdata[rshift +: 8];

        case (state_q)
            IDLE: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (exec) begin
                    state_d    = ACCESS;
                    mem_req_d  = 1'b1;
                    // A request flagged as both load and store is executed as a load
                    mem_we_d   = is_store & ~is_load;
                    mem_addr_d = addr;
                    load_d     = is_load;
                    wb_d       = wb_base;
                    byte_d     = size_byte;
                    rd_d       = rd;
                    rn_d       = rn;
                    base_d     = base_new;
                    if (size_byte) begin
                        mem_be_d    = BE_W'(1) << addr[LANE_W-1:0];
                        mem_wdata_d = {BE_W{store_data[7:0]}};
                    end else begin
                        mem_be_d    = '1;
                        mem_wdata_d = store_data;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d      = DONE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    rf_w_en1_d   = load_q;
                    rf_w_addr1_d = rd_q;
                    rf_w_data1_d = byte_q ? {{(DATA_W-8){1'b0}}, rbyte} : mem_rdata;
                    rf_w_en2_d   = wb_q & ~(load_q && (rd_q == rn_q));
                    rf_w_addr2_d = rn_q;
                    rf_w_data2_d = base_q;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    fault_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            rf_w_en1_q   <= 1'b0;
            rf_w_addr1_q <= '0;
            rf_w_data1_q <= '0;
            rf_w_en2_q   <= 1'b0;
            rf_w_addr2_q <= '0;
            rf_w_data2_q <= '0;
            load_q       <= 1'b0;
            wb_q         <= 1'b0;
            byte_q       <= 1'b0;
            rd_q         <= '0;
            rn_q         <= '0;
            base_q       <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            rf_w_en1_q   <= rf_w_en1_d;
            rf_w_addr1_q <= rf_w_addr1_d;
            rf_w_data1_q <= rf_w_data1_d;
            rf_w_en2_q   <= rf_w_en2_d;
            rf_w_addr2_q <= rf_w_addr2_d;
            rf_w_data2_q <= rf_w_data2_d;
            load_q       <= load_d;
            wb_q         <= wb_d;
            byte_q       <= byte_d;
            rd_q         <= rd_d;
            rn_q         <= rn_d;
            base_q       <= base_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign rf_w_en1   = rf_w_en1_q;
    assign rf_w_addr1 = rf_w_addr1_q;
    assign rf_w_data1 = rf_w_data1_q;
    assign rf_w_en2   = rf_w_en2_q;
    assign rf_w_addr2 = rf_w_addr2_q;
    assign rf_w_data2 = rf_w_data2_q;
`ifdef MEM_TIMEOUT_EN
    assign fault      = fault_q;
`else
    assign fault      = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, status_reg[27:0], (TIMEOUT_CYC > 0)};

endmodule
